// File: rtl/digit_scan_ctrl.sv
// Multiplexed seven-segment digit-enable scanner with refresh prescaler, blanking
// mask and anti-ghosting blank window. Optional dimming via macro SCAN_DIM_EN.
module digit_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1,
    localparam int SEL_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
`ifdef SCAN_DIM_EN
    input  logic [3:0]            duty,
`endif
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEL_W-1:0]      digit_sel,
    output logic                  slot_tick,
    output logic                  frame_done
);

    // phase | meaning
    // BLANK | cnt < BLANK_CYCLES: every digit off so the segment bus can settle
    // DRIVE | cnt >= BLANK_CYCLES: digit_sel lit unless masked (or dimmed)
    typedef enum logic {
        BLANK,
        DRIVE
    } phase_t;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0]      SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE      = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [SEL_W-1:0]      sel_next;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  tick_next;
    logic                  frame_next;
    logic                  pwm_ok;
    phase_t                phase_next;

`ifdef SCAN_DIM_EN
    logic [3:0] pwm;
    logic [3:0] pwm_next;

    assign pwm_next = pwm + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) pwm <= 4'd0;
        else       pwm <= pwm_next;
    end

    // pwm_next is compared so the duty gate lines up with the registered an
    assign pwm_ok = (duty == 4'hF) || (pwm_next < duty);
`else
    assign pwm_ok = 1'b1;
`endif

    always_comb begin
        cnt_next   = cnt;
        sel_next   = digit_sel;
        tick_next  = 1'b0;
        frame_next = 1'b0;
        if (en) begin
            if (cnt == CNT_LAST) begin
                cnt_next   = '0;
                sel_next   = (digit_sel == SEL_LAST) ? '0 : digit_sel + 1'b1;
                tick_next  = 1'b1;
                frame_next = (sel_next == '0);
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            cnt_next = '0;
        end

        // an is computed from the next count so that it tracks cnt cycle for cycle
        phase_next = (int'(cnt_next) < BLANK_CYCLES) ? BLANK : DRIVE;
        onehot     = '0;
        if (en && phase_next == DRIVE && !digit_mask[sel_next] && pwm_ok)
            onehot = ONE << sel_next;
        an_next = (ACTIVE_LOW != 0) ? ~onehot : onehot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            digit_sel  <= '0;
            an         <= AN_OFF;
            slot_tick  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            digit_sel  <= sel_next;
            an         <= an_next;
            slot_tick  <= tick_next;
            frame_done <= frame_next;
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed self-checking bench for digit_scan_ctrl: a 4-digit active-low scanner
// and a 3-digit active-high, zero-blank scanner run side by side.
module tb_digit_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] mask_a;
    logic [2:0] mask_b;
    logic [3:0] an_a;
    logic [1:0] sel_a;
    logic       tick_a;
    logic       frame_a;
    logic [2:0] an_b;
    logic [1:0] sel_b;
    logic       tick_b;
    logic       frame_b;
`ifdef SCAN_DIM_EN
    logic [3:0] duty;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    digit_scan_ctrl #(
        .NUM_DIGITS(4), .PRESCALE(10), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en), .digit_mask(mask_a),
`ifdef SCAN_DIM_EN
        .duty(duty),
`endif
        .an(an_a), .digit_sel(sel_a), .slot_tick(tick_a), .frame_done(frame_a)
    );

    digit_scan_ctrl #(
        .NUM_DIGITS(3), .PRESCALE(4), .BLANK_CYCLES(0), .ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en), .digit_mask(mask_b),
`ifdef SCAN_DIM_EN
        .duty(duty),
`endif
        .an(an_b), .digit_sel(sel_b), .slot_tick(tick_b), .frame_done(frame_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench in cycle 0: reset just released, outputs still at reset values.
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        logic [3:0] ea;
        logic [2:0] eb;
        int         slot;
        int         pos;

        reset  = 1'b1;
        en     = 1'b1;
        mask_a = 4'b0000;
        mask_b = 3'b000;
`ifdef SCAN_DIM_EN
        duty   = 4'hF;
`endif

        // Free run: first slots, frame wrap, and the 3-digit no-blank instance.
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            slot = c / 10;
            pos  = c % 10;
            ea   = 4'b1111;
            if (pos >= 2) ea[slot % 4] = 1'b0;
            check("run_an", 32'(an_a), 32'(ea));
            check("run_sel", 32'(sel_a), 32'(slot % 4));
            check("run_tick", 32'(tick_a), 32'((pos == 0 && c > 0) ? 1 : 0));
            check("run_frame", 32'(frame_a), 32'((c == 40) ? 1 : 0));

            eb = 3'b000;
            if (c > 0) eb[(c / 4) % 3] = 1'b1;
            check("np2_an", 32'(an_b), 32'(eb));
            check("np2_sel", 32'(sel_b), 32'((c / 4) % 3));
            check("np2_tick", 32'(tick_b), 32'((c % 4 == 0 && c > 0) ? 1 : 0));
            check("np2_frame", 32'(frame_b), 32'((c % 12 == 0 && c > 0) ? 1 : 0));
            step();
        end

        // Mask digit 1 mid-slot.
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            if (c >= 12 && c <= 14) check("mask_pre", 32'(an_a), 32'(4'b1101));
            if (c >= 15 && c <= 19) check("mask_on", 32'(an_a), 32'(4'b1111));
            if (c == 20) check("mask_tick", 32'(tick_a), 32'(1));
            if (c >= 22 && c <= 29) check("mask_slot2", 32'(an_a), 32'(4'b1011));
            if (c == 14) mask_a = 4'b0010;
            step();
        end
        mask_a = 4'b0000;

        // Enable drop during digit 2.
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            if (c == 25) check("endrop_pre", 32'(an_a), 32'(4'b1011));
            if (c >= 26 && c <= 31) begin
                check("endrop_an", 32'(an_a), 32'(4'b1111));
                check("endrop_sel", 32'(sel_a), 32'(2));
                check("endrop_tick", 32'(tick_a), 32'(0));
            end
            if (c >= 32 && c <= 39) check("endrop_resume", 32'(an_a), 32'(4'b1011));
            if (c == 40) begin
                check("endrop_tick40", 32'(tick_a), 32'(1));
                check("endrop_sel40", 32'(sel_a), 32'(3));
                check("endrop_frame40", 32'(frame_a), 32'(0));
            end
            if (c == 25) en = 1'b0;
            if (c == 30) en = 1'b1;
            step();
        end

        // Reset asserted mid-scan with en held high.
        do_reset();
        for (int c = 0; c < 17; c++) step();
        check("rstp_pre", 32'(an_a), 32'(4'b1101));
        reset = 1'b1;
        step();
        check("rstp_an", 32'(an_a), 32'(4'b1111));
        check("rstp_sel", 32'(sel_a), 32'(0));
        check("rstp_tick", 32'(tick_a), 32'(0));
        check("rstp_frame", 32'(frame_a), 32'(0));
        reset = 1'b0;
        cyc   = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c >= 2 && c <= 9) check("rstp_d0", 32'(an_a), 32'(4'b1110));
            if (c == 10) begin
                check("rstp_tick10", 32'(tick_a), 32'(1));
                check("rstp_sel10", 32'(sel_a), 32'(1));
                check("rstp_blank10", 32'(an_a), 32'(4'b1111));
            end
            if (c == 12) check("rstp_d1", 32'(an_a), 32'(4'b1101));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Parametrised multiplexed seven-segment digit-enable scanner. It is the successor to the fixed 8-digit one-hot rotator in TextDisplay. It has an internal refresh prescaler, a configurable digit count and enable polarity, a per-digit blanking mask, and an anti-ghosting blank window at the start of each digit slot. It drives the anode lines and provides the digit index that the segment-data mux uses, keeping both aligned.

Parameters:
NUM_DIGITS, 8, number of digits scanned; legal range is 2 or more.
PRESCALE, 100000, clk cycles per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, cycles at the start of each slot during which all digits are off; 0 is legal.
ACTIVE_LOW, 1, 1 means an enabled digit drives 0 on an; 0 means it drives 1.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
en  in  1  scan enable.
digit_mask  in  NUM_DIGITS  bit i = 1 forces digit i off (its slot still elapses).
an  out  NUM_DIGITS  digit enables; an[0] is the right-most digit.
digit_sel  out  max(1,$clog2(NUM_DIGITS))  index of the current slot's digit.
slot_tick  out  1  one-cycle pulse in the first cycle of each new slot.
frame_done  out  1  one-cycle pulse in the first cycle of slot 0 after a wrap.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. It takes priority over en.
- Reset values:
  - Internal slot counter cnt = 0, digit_sel = 0.
  - an = all-off: all 1s if ACTIVE_LOW, all 0s otherwise.
  - slot_tick = 0, frame_done = 0.
- All outputs are registered. an, digit_sel and the pulses change only on clk edges.
- Slot counter: cnt counts 0..PRESCALE-1 while en = 1. At PRESCALE-1 it wraps to 0 and digit_sel advances (i+1) mod NUM_DIGITS. Scan order is 0, 1, …, NUM_DIGITS-1, 0.
- States per slot:
  - BLANK while cnt < BLANK_CYCLES: an is all-off.
  - DRIVE while cnt >= BLANK_CYCLES: only bit digit_sel of an is asserted, and only if digit_mask[digit_sel] = 0; all other bits are off.
- an alignment: an is aligned to cnt. In the cycle where cnt = k, an reflects state k.
- Pulses:
  - slot_tick is high exactly in the cycle where cnt = 0 following a wrap.
  - frame_done is high in the same cycle when the new digit_sel = 0.
  - No pulses occur in the first slot after reset or after en rises.
- digit_mask: sampled every cycle. A change takes effect on an in the next cycle, including mid-slot.
- en = 0:
  - cnt is cleared to 0, digit_sel holds, an is all-off, pulses are 0.
  - When en returns to 1, the scan resumes at the held digit with a full BLANK window.
- Reset mid-scan: the next cycle shows reset values regardless of en. After reset is released, scanning restarts at digit 0.
- Degenerate cases:
  - BLANK_CYCLES = 0: the DRIVE state covers the entire slot.
  - NUM_DIGITS not a power of 2: digit_sel wraps explicitly at NUM_DIGITS-1 and never takes values ≥ NUM_DIGITS.

Optional Feature:
Macro SCAN_DIM_EN.
- Defined:
  - Adds input port duty (4 bits) and a free-running 4-bit pwm counter. The counter resets to 0 and increments every cycle regardless of en.
  - In the DRIVE state, the selected digit is asserted only when pwm < duty, or when duty = 4'hF (full on).
  - duty = 0 keeps all digits off; BLANK behaviour and the pulses are unchanged.
- Undefined:
  - No duty port and no pwm counter; the DRIVE state is always full on.

Test Plan:
Reset/first slots: NUM_DIGITS=4, PRESCALE=10, BLANK_CYCLES=2, ACTIVE_LOW=1, en=1, mask=0, release reset at cycle 0.
- Cycles 0–1: an=1111.
- Cycles 2–9: an=1110, digit_sel=0.
- Cycles 10–11: an=1111.
- Cycles 12–19: an=1101.
- slot_tick high at cycle 10 only (no pulse at cycle 0).

Frame wrap: continue the same run.
- an=1011 over cycles 22–29 and 0111 over cycles 32–39.
- At cycle 40: digit_sel=0, slot_tick=1 and frame_done=1.
- frame_done is low at cycles 10, 20 and 30.

Mask: set digit_mask=0010 at cycle 14.
- From cycle 15: an=1111 for the rest of slot 1.
- Slot 2 is unaffected: an=1011.
- The slot timing is unchanged.

Enable drop: drop en at cycle 25 (digit 2), hold low 5 cycles, raise at cycle 30.
- Cycles 26–31: an=1111.
- digit_sel stays 2.
- an=1011 from cycle 32 to cycle 39.
- slot_tick at cycle 40 with digit_sel=3.

Reset priority: assert reset at cycle 17 with en=1.
- Cycle 18: an=1111, digit_sel=0, no pulses.
- The scan restarts from digit 0 once reset deasserts.

SCAN_DIM_EN: duty=4.
- In DRIVE, the selected digit is asserted 4 of every 16 cycles.
- duty=0 gives an=1111 constantly.
- duty=15 gives waveforms identical to the undefined-macro build.
